pa_oddeven_sort_ctrl: RTL
=========================

# pa_oddeven_sort_ctrl

Serial-in / serial-out sorter that time-shares one `PA_swap_and_compare` instance over an internal register buffer of NUM_ELEM words. It sequences an odd-even transposition sort, one compare-and-swap per clock. It accepts a frame of exactly NUM_ELEM words on a valid/ready input stream, sorts it in ascending or descending order, then streams the result out on a valid/ready output. It sits between a sample source and any consumer needing an ordered frame, such as a median or rank selection stage.

## Interface
- SIZE_DATA, 8: element width in bits; passed to the compare-and-swap instance.
- NUM_ELEM, 8: words per frame; legal values are 2 and above.
- i_clk, input, 1: clock; all state changes on the rising edge.
- i_rst_n, input, 1: asynchronous, active-low reset.
- i_mode, input, 1: 0 sorts ascending, 1 sorts descending. Sampled only when element 0 of a frame is accepted.
- i_in_valid, input, 1: input word valid.
- o_in_ready, output, 1: the block can accept an input word.
- i_in_data, input, SIZE_DATA: input word (unsigned).
- o_out_valid, output, 1: output word valid.
- i_out_ready, input, 1: the consumer accepts the output word.
- o_out_data, output, SIZE_DATA: output word. Equals 0 whenever o_out_valid is 0.
- o_out_last, output, 1: marks the final word of the frame (index NUM_ELEM-1).
- o_busy, output, 1: high in the SORT and DRAIN states.

## Operation
- States: IDLE, LOAD, SORT, DRAIN. Reset enters IDLE.
- IDLE / LOAD:
  - o_in_ready=1.
  - A handshake (i_in_valid & o_in_ready) writes buf[wr_idx] and increments wr_idx.
  - The first handshake latches i_mode into mode_q and moves IDLE to LOAD. i_mode changes after that point are ignored.
  - The handshake at wr_idx=NUM_ELEM-1 moves to SORT and clears the pass and pair counters.
- SORT:
  - o_in_ready=0.
  - Pass p runs from 0 to NUM_ELEM-1.
  - Even pass pairs are (0,1),(2,3),…; there are floor(NUM_ELEM/2) of them.
  - Odd pass pairs are (1,2),(3,4),…; there are floor((NUM_ELEM-1)/2) of them.
  - Each cycle one pair (j, j+1) drives the compare unit: i_data_a=buf[j], i_data_b=buf[j+1], i_mode=mode_q.
  - At the clock edge, buf[j] gets o_less_data and buf[j+1] gets o_greater_data.
  - A pass with zero pairs takes zero cycles.
  - After the last pair of pass NUM_ELEM-1, move to DRAIN with rd_idx=0.
- DRAIN:
  - o_out_valid=1 and o_out_data=buf[rd_idx]; o_out_last=(rd_idx==NUM_ELEM-1).
  - A handshake increments rd_idx.
  - The handshake on the last word returns to IDLE, so the next frame can load on the following cycle.
- Word ordering: inputs are stored in index order and outputs are read in index order (index 0 first).
- Equal keys: the compare unit moves the words regardless, and any resulting order of equal values is acceptable.
- Width rule: the buffer is NUM_ELEM×SIZE_DATA. Indexes are $clog2(NUM_ELEM) bits wide, or 1 bit when NUM_ELEM=2.

## Timing
- Reset values (asynchronous, immediate):
  - o_in_ready=1.
  - o_out_valid=0, o_out_data=0, o_out_last=0, o_busy=0.
  - wr_idx, rd_idx and all counters are 0; mode_q=0.
  - Buffer contents are don't-care.
- Sort cycles: P = ceil(NUM_ELEM/2)·floor(NUM_ELEM/2) + floor(NUM_ELEM/2)·floor((NUM_ELEM-1)/2).
  - Equivalently, P is the sum of the pair counts over all NUM_ELEM passes.
  - NUM_ELEM=8 gives P=28; NUM_ELEM=2 gives P=1; NUM_ELEM=5 gives P=10.
- Latency: if the last input handshake occurs in cycle k, SORT occupies cycles k+1…k+P, and o_out_valid first rises in cycle k+P+1.
- Output holding: o_out_data and o_out_last stay stable while o_out_valid=1 and i_out_ready=0.
- Input stalls: gaps in i_in_valid only stall the load; no words are lost or duplicated.
- i_out_ready is ignored outside DRAIN, and i_in_valid is ignored in SORT and DRAIN.
- Reset asserted mid-LOAD, mid-SORT or mid-DRAIN aborts the frame and returns to IDLE with the reset values above. The frame after reset is sorted correctly.
- Throughput: at most one frame every NUM_ELEM + P + NUM_ELEM cycles when there are no stalls.

## Test plan
- Reset: assert i_rst_n=0 mid-clock -> outputs take their reset values immediately, without waiting for a clock edge.
- Ascending sort, NUM_ELEM=8, mode 0: load 5,3,8,1,9,2,7,4 with no stalls -> output 1,2,3,4,5,7,8,9 with o_out_last on 9. First o_out_valid at k+29 after the last accept in cycle k, and o_busy high for exactly 28+8 cycles with i_out_ready=1.
- Descending sort with duplicates, mode 1: load FF,00,80,80,01,FF,02,00 -> output FF,FF,80,80,02,01,00,00.
- Backpressure: random i_in_valid gaps and i_out_ready toggling -> same sorted result. o_out_data is held while stalled, and exactly 8 output handshakes occur per frame.
- Mode latch and abort:
  - Toggle i_mode after element 0 -> the direction follows the value sampled at element 0.
  - Pulse i_rst_n low during cycle 10 of SORT -> back in IDLE with o_in_ready=1. The next frame (an already-sorted 0..7 loaded in mode 1) outputs 7..0.
- Back-to-back frames:
  - o_in_ready=0 throughout SORT/DRAIN, and the second frame is accepted the cycle after the first frame's last output handshake.
  - With NUM_ELEM=2 overridden, loading 9,3 gives 3,9 with P=1.

Source files
------------

// File: rtl/pa_oddeven_sort_ctrl.sv
// Serial-in / serial-out odd-even transposition sorter. One compare-and-swap
// unit is time-shared over an internal NUM_ELEM-word buffer, one pair per clock.

module PA_swap_and_compare #(
    parameter int unsigned SIZE_DATA = 8
) (
    input  logic [SIZE_DATA-1:0] i_data_a,
    input  logic [SIZE_DATA-1:0] i_data_b,
    input  logic                 i_mode,
    output logic [SIZE_DATA-1:0] o_less_data,
    output logic [SIZE_DATA-1:0] o_greater_data
);
    logic swap_c;

    // In descending mode the "less" slot receives the larger word.
    assign swap_c         = i_mode ? (i_data_b > i_data_a) : (i_data_a > i_data_b);
    assign o_less_data    = swap_c ? i_data_b : i_data_a;
    assign o_greater_data = swap_c ? i_data_a : i_data_b;
endmodule

module pa_oddeven_sort_ctrl #(
    parameter int unsigned SIZE_DATA = 8,
    parameter int unsigned NUM_ELEM  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_mode,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [SIZE_DATA-1:0] i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [SIZE_DATA-1:0] o_out_data,
    output logic                 o_out_last,
    output logic                 o_busy
);
    localparam int unsigned IW      = (NUM_ELEM <= 2) ? 1 : $clog2(NUM_ELEM);
    localparam int unsigned NP_EVEN = NUM_ELEM / 2;
    localparam int unsigned NP_ODD  = (NUM_ELEM - 1) / 2;
    // A trailing pass with no pairs (only possible for NUM_ELEM=2) is skipped.
    localparam int unsigned LAST_PASS = (NP_ODD == 0) ? NUM_ELEM - 2 : NUM_ELEM - 1;

    localparam logic [IW-1:0] LAST_IDX       = IW'(NUM_ELEM - 1);
    localparam logic [IW-1:0] PASS_LAST      = IW'(LAST_PASS);
    localparam logic [IW-1:0] PAIR_LAST_EVEN = IW'(NP_EVEN - 1);
    localparam logic [IW-1:0] PAIR_LAST_ODD  = (NP_ODD == 0) ? '0 : IW'(NP_ODD - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SORT, S_DRAIN} state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         wr_idx_q, wr_idx_d;
    logic [IW-1:0]         rd_idx_q, rd_idx_d;
    logic [IW-1:0]         pass_q, pass_d;
    logic [IW-1:0]         pair_q, pair_d;
    logic                  mode_q, mode_d;
    logic [SIZE_DATA-1:0]  mem_q [NUM_ELEM];
    logic [SIZE_DATA-1:0]  mem_d [NUM_ELEM];

    logic                  o_in_ready_q, o_in_ready_d;
    logic                  o_out_valid_q, o_out_valid_d;
    logic [SIZE_DATA-1:0]  o_out_data_q, o_out_data_d;
    logic                  o_out_last_q, o_out_last_d;
    logic                  o_busy_q, o_busy_d;

    logic                  in_hs_c, out_hs_c;
    logic [IW-1:0]         pair_lo_c, pair_hi_c, pair_last_c;
    logic [SIZE_DATA-1:0]  less_c, greater_c;

    assign in_hs_c     = o_in_ready_q & i_in_valid;
    assign out_hs_c    = o_out_valid_q & i_out_ready;
    assign pair_lo_c   = IW'(32'(pair_q) * 2 + 32'(pass_q[0]));
    assign pair_hi_c   = pair_lo_c + IW'(1);
    assign pair_last_c = pass_q[0] ? PAIR_LAST_ODD : PAIR_LAST_EVEN;

    PA_swap_and_compare #(.SIZE_DATA(SIZE_DATA)) u_cmp (
        .i_data_a       (mem_q[pair_lo_c]),
        .i_data_b       (mem_q[pair_hi_c]),
        .i_mode         (mode_q),
        .o_less_data    (less_c),
        .o_greater_data (greater_c)
    );

    // Next-state, buffer update and registered-output computation.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        pass_d   = pass_q;
        pair_d   = pair_q;
        mode_d   = mode_q;
        mem_d    = mem_q;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_hs_c) begin
                    mem_d[wr_idx_q] = i_in_data;
                    state_d         = S_LOAD;
                    if (state_q == S_IDLE) begin
                        mode_d = i_mode;
                    end
                    if (wr_idx_q == LAST_IDX) begin
                        state_d  = S_SORT;
                        wr_idx_d = '0;
                        pass_d   = '0;
                        pair_d   = '0;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            S_SORT: begin
                mem_d[pair_lo_c] = less_c;
                mem_d[pair_hi_c] = greater_c;
                if (pair_q == pair_last_c) begin
                    pair_d = '0;
                    if (pass_q == PASS_LAST) begin
                        state_d  = S_DRAIN;
                        rd_idx_d = '0;
                    end else begin
                        pass_d = pass_q + IW'(1);
                    end
                end else begin
                    pair_d = pair_q + IW'(1);
                end
            end
            S_DRAIN: begin
                if (out_hs_c) begin
                    if (rd_idx_q == LAST_IDX) begin
                        state_d  = S_IDLE;
                        rd_idx_d = '0;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        o_in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);
        o_out_valid_d = (state_d == S_DRAIN);
        o_out_data_d  = (state_d == S_DRAIN) ? mem_d[rd_idx_d] : '0;
        o_out_last_d  = (state_d == S_DRAIN) && (rd_idx_d == LAST_IDX);
        o_busy_d      = (state_d == S_SORT) || (state_d == S_DRAIN);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            pass_q        <= '0;
            pair_q        <= '0;
            mode_q        <= 1'b0;
            mem_q         <= '{default: '0};
            o_in_ready_q  <= 1'b1;
            o_out_valid_q <= 1'b0;
            o_out_data_q  <= '0;
            o_out_last_q  <= 1'b0;
            o_busy_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            pass_q        <= pass_d;
            pair_q        <= pair_d;
            mode_q        <= mode_d;
            mem_q         <= mem_d;
            o_in_ready_q  <= o_in_ready_d;
            o_out_valid_q <= o_out_valid_d;
            o_out_data_q  <= o_out_data_d;
            o_out_last_q  <= o_out_last_d;
            o_busy_q      <= o_busy_d;
        end
    end

    assign o_in_ready  = o_in_ready_q;
    assign o_out_valid = o_out_valid_q;
    assign o_out_data  = o_out_data_q;
    assign o_out_last  = o_out_last_q;
    assign o_busy      = o_busy_q;
endmodule
